// File: rtl/fir_out_sink.sv
// Receiving end of the FIR sample stream: aligns the input strobe to the filter latency, drops the
// warm-up outputs and queues valid samples in a show-ahead FIFO. Define FIR_SINK_DECIM_EN to keep
// only one of every DECIM post-warm-up samples.
module fir_out_sink #(
    parameter int unsigned WW_DATA  = 8,
    parameter int unsigned LATENCY  = 3,
    parameter int unsigned N_WARMUP = 14,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DECIM    = 2
) (
    input  logic                     clk,
    input  logic                     i_srst,
    input  logic                     i_en,
    input  logic [WW_DATA-1:0]       i_data,
    input  logic                     i_restart,
    input  logic                     i_clr_ovf,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WW_DATA-1:0]       o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic                     o_warm
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned WCW = (N_WARMUP > 1) ? $clog2(N_WARMUP) : 1;

    typedef enum logic [0:0] {StWarmup, StRun} state_e;

    localparam state_e StReset = (N_WARMUP == 0) ? StRun : StWarmup;

    state_e             state_q, state_d;
    logic [WCW-1:0]     warm_cnt_q, warm_cnt_d;
    logic [LATENCY-1:0] en_pipe_q, en_pipe_d;
    logic [LATENCY:0]   en_shift;
    logic               cap;
    logic               run_cap;
    logic               push_cand;

    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [WW_DATA-1:0] mem_q [DEPTH];
    logic [WW_DATA-1:0] o_data_q, o_data_d;
    logic               ovf_q, ovf_d;
    logic               full, empty, pop, push, ovf_set;

    // Strobe delay line: a strobe reaches the top bit on the edge its filter output is ready.
    always_comb begin
        en_shift  = {en_pipe_q, i_en};
        en_pipe_d = en_shift[LATENCY-1:0];
        cap       = en_pipe_q[LATENCY-1];
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        run_cap    = 1'b0;
        if (i_restart) begin
            state_d    = StReset;
            warm_cnt_d = '0;
        end else if (cap) begin
            unique case (state_q)
                StWarmup: begin
                    if (warm_cnt_q == WCW'(N_WARMUP - 1)) begin
                        state_d    = StRun;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
                StRun:    run_cap = 1'b1;
                default:  state_d = StReset;
            endcase
        end
    end

`ifdef FIR_SINK_DECIM_EN
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [DW-1:0] dec_cnt_q, dec_cnt_d;

    always_comb begin
        push_cand = run_cap && (dec_cnt_q == '0);
        dec_cnt_d = dec_cnt_q;
        if (i_restart || state_q != StRun) begin
            dec_cnt_d = '0;
        end else if (run_cap) begin
            dec_cnt_d = (dec_cnt_q == DW'(DECIM - 1)) ? '0 : dec_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_srst) dec_cnt_q <= '0;
        else        dec_cnt_q <= dec_cnt_d;
    end
`else
    always_comb push_cand = run_cap;
`endif

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = !empty && i_ready;
        push     = push_cand && (!full || pop);
        ovf_set  = push_cand && full && !pop;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        ovf_d    = ovf_set ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
    end

    // Registered head; a sample written into an empty queue becomes the head on the same edge.
    always_comb begin
        o_data_d = o_data_q;
        if (wr_ptr_d != rd_ptr_d) begin
            if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) o_data_d = i_data;
            else                                                o_data_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (i_srst) begin
            state_q    <= StReset;
            warm_cnt_q <= '0;
            en_pipe_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            o_data_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            en_pipe_q  <= en_pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            o_data_q   <= o_data_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        o_valid    = !empty;
        o_data     = o_data_q;
        o_level    = wr_ptr_q - rd_ptr_q;
        o_overflow = ovf_q;
        o_warm     = (state_q == StRun);
    end

endmodule
